// File: rtl/win_led_sequencer.sv
// win_led_sequencer
//   Turns a raw win-detect result into a timed RGB LED sequence. A new result
//   is latched in IDLE, its colour blinks BLINKS times (HALF_PERIOD cycles on,
//   HALF_PERIOD cycles off), and then it is held at PWM-dimmed brightness until
//   clear. Every output is registered, so the LED never shows detect_win
//   directly.
//
//   Control inputs are plain level/pulse signals sampled on the rising clock
//   edge; there is no valid/ready handshake on this block.
//   - clear:      one-cycle request that has priority over everything else.
//   - detect_win: looked at only in IDLE, and only while armed. armed is set
//                 again by any edge that sees detect_win==00, so a stale
//                 result cannot retrigger a sequence.
module win_led_sequencer #(
    parameter int HALF_PERIOD = 4,
    parameter int BLINKS      = 3,
    parameter int PWM_BITS    = 4,
    parameter int HOLD_DUTY   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] detect_win,
    input  logic       clear,
    output logic [2:0] LED_out,
    output logic       busy,
    output logic       seq_done
);

    localparam int TW = (HALF_PERIOD < 1) ? 1 : $clog2(HALF_PERIOD + 1);
    localparam int BW = (BLINKS < 1) ? 1 : $clog2(BLINKS + 1);

    localparam logic [TW-1:0]     TIMER_LAST = TW'(HALF_PERIOD - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINKS);
    localparam logic [PWM_BITS:0] DUTY       = (PWM_BITS + 1)'(HOLD_DUTY);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BLINK_ON  = 2'd1,
        ST_BLINK_OFF = 2'd2,
        ST_HOLD      = 2'd3
    } state_e;

    state_e              state_q,     state_d;
    logic [TW-1:0]       timer_q,     timer_d;
    logic [BW-1:0]       blink_cnt_q, blink_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q,   pwm_cnt_d;
    logic [1:0]          win_q,       win_d;
    logic                armed_q,     armed_d;
    logic [2:0]          led_q,       led_d;
    logic                busy_q,      busy_d;
    logic                seq_done_q,  seq_done_d;

    // The outcome colour is {R,G,B}: player1 red, player2 blue, draw green.
    function automatic logic [2:0] colour_of(input logic [1:0] win);
        logic [2:0] c;
        c = 3'b000;
        case (win)
            2'b01:   c = 3'b100;
            2'b10:   c = 3'b001;
            2'b11:   c = 3'b010;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    // This register bank holds the state, counters, latched result and the
    // registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            blink_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            win_q       <= 2'b00;
            armed_q     <= 1'b1;
            led_q       <= 3'b000;
            busy_q      <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            blink_cnt_q <= blink_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            win_q       <= win_d;
            armed_q     <= armed_d;
            led_q       <= led_d;
            busy_q      <= busy_d;
            seq_done_q  <= seq_done_d;
        end
    end

    // This block computes the next state and counters, then derives the
    // outputs from that next state. Doing it that way means the registered
    // outputs line up with the state they describe.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        blink_cnt_d = blink_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        win_d       = win_q;
        armed_d     = armed_q;
        seq_done_d  = 1'b0;
        led_d       = 3'b000;
        busy_d      = 1'b0;

        // Re-arming does not depend on clear or on the current state.
        if (detect_win == 2'b00) begin
            armed_d = 1'b1;
        end

        if (clear) begin
            state_d     = ST_IDLE;
            timer_d     = '0;
            blink_cnt_d = '0;
            pwm_cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (detect_win != 2'b00 && armed_q) begin
                        win_d       = detect_win;
                        timer_d     = '0;
                        blink_cnt_d = '0;
                        armed_d     = 1'b0;
                        state_d     = ST_BLINK_ON;
                    end
                end
                ST_BLINK_ON: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d = '0;
                        state_d = ST_BLINK_OFF;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_BLINK_OFF: begin
                    if (timer_q == TIMER_LAST) begin
                        timer_d     = '0;
                        blink_cnt_d = blink_cnt_q + 1'b1;
                        if (blink_cnt_q + 1'b1 == BLINK_LAST) begin
                            pwm_cnt_d  = '0;
                            seq_done_d = 1'b1;
                            state_d    = ST_HOLD;
                        end else begin
                            state_d = ST_BLINK_ON;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // The counter wraps naturally at 2**PWM_BITS.
                    pwm_cnt_d = pwm_cnt_q + 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_BLINK_ON: led_d = colour_of(win_d);
            ST_HOLD:     led_d = ({1'b0, pwm_cnt_d} < DUTY) ? colour_of(win_d) : 3'b000;
            default:     led_d = 3'b000;
        endcase
    end

    assign LED_out  = led_q;
    assign busy     = busy_q;
    assign seq_done = seq_done_q;

endmodule
